// File: rtl/clock_div_ctrl_if.sv
// Divisor-update handshake between a configuring master and clock_div_ctrl.
`timescale 1ns/1ps
interface clock_div_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [CNT_W-1:0] div_val;
  logic             div_valid;
  logic             div_ready;

  modport master (
    output div_val,
    output div_valid,
    input  div_ready
  );

  modport slave (
    input  div_val,
    input  div_valid,
    output div_ready
  );
endinterface

// File: rtl/clock_div_ctrl.sv
// Programmable integer clock divider; new divisors take effect only at period boundaries.
// Optional CLKDIV_CTRL_PERIOD_CNT_EN adds a completed-period counter output.
`timescale 1ns/1ps
module clock_div_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             clk_in,
  input  logic             nReset,
  input  logic             en,
  clock_div_ctrl_if.slave  cfg,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_div
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [CNT_W-1:0] period_cnt
`endif
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);
  localparam int unsigned      HalfW  = CNT_W + 1;

  typedef enum logic [0:0] {StStop, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             boundary;
  logic             apply;
  logic [CNT_W:0]   half;

  assign boundary = (state_q == StRun) && (cnt_q == (cur_div_q - CNT_W'(1)));

  always_ff @(posedge clk_in or negedge nReset) begin
    if (!nReset) begin
      state_q <= StStop;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStop:  if (en) state_d = StRun;
      StRun:   if (boundary && !en) state_d = StStop;
      default: state_d = StStop;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;

    // A divisor pending in STOP is applied right away; in RUN only at the wrap.
    apply = pend_q && ((state_q == StStop) || boundary);
    if (apply) begin
      cur_div_d = pend_val_q;
      pend_d    = 1'b0;
    end
    if (cfg.div_valid && !pend_q) begin
      pend_d     = 1'b1;
      pend_val_d = (cfg.div_val < MinDiv) ? MinDiv : cfg.div_val;
    end

    if ((state_d == StRun) && (state_q == StRun) && !boundary) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    // High phase is ceil(N/2) counts of the period being entered.
    half      = ({1'b0, cur_div_d} + HalfW'(1)) >> 1;
    clk_out_d = (state_d == StRun) && ({1'b0, cnt_d} < half);
    tick_d    = (state_d == StRun) && (cnt_d == '0);
  end

  always_ff @(posedge clk_in or negedge nReset) begin
    if (!nReset) begin
      cnt_q      <= '0;
      cur_div_q  <= DefDiv;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign cfg.div_ready = ~pend_q;
  assign clk_out       = clk_out_q;
  assign tick          = tick_q;
  assign running       = (state_q == StRun);
  assign cur_div       = cur_div_q;

`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  logic [CNT_W-1:0] period_cnt_q;

  always_ff @(posedge clk_in or negedge nReset) begin
    if (!nReset) begin
      period_cnt_q <= '0;
    end else if (boundary) begin
      period_cnt_q <= period_cnt_q + CNT_W'(1);
    end
  end

  assign period_cnt = period_cnt_q;
`else
  // Period counter not built.
`endif

endmodule
